stage_exe: RTL and testbench
============================

# stage_exe

Execute stage of the five-stage in-order pipeline, sitting between decode and `stage_mem`. It latches operands and control from decode, computes the ALU result (including multi-cycle 32-bit divide/modulo), and issues the data-SRAM request for loads and stores. It hands `stage_mem` the PC, ALU result, load flag and write-back fields, and forwards its result back to decode.

## Interface
- No parameters.
- `clk  in  1  ` clock; all state updates on the rising edge.
- `rst  in  1  ` reset, asynchronous, active-high.
- `validin / allowout  in  1 / 1  ` upstream valid, downstream (MEM) ready.
- `allowin / validout  out  1 / 1  ` ready to upstream, valid to MEM.
- `input_pc / output_pc  in / out  32 / 32  ` trace PC.
- `input_rf_waddr / output_rf_waddr  in / out  5 / 5  ` write-back register.
- `input_rf_we / output_rf_we  in / out  1 / 1  ` write-back enable.
- `input_alu_op  in  4  ` 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 NOR, 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 DIV, 13 MOD, 14 DIVU, 15 MODU.
- `input_alu_src1 / input_alu_src2  in  32 / 32  ` operands.
- `input_mem_read / input_mem_write  in  1 / 1  ` load / store (word only).
- `input_store_data  in  32  ` store data.
- `output_mem_read  out  1  ` load flag to MEM.
- `output_alu_result  out  32  ` result (load/store address for memory ops).
- `data_sram_en  out  1  ` SRAM request.
- `data_sram_we  out  4  ` byte write enables.
- `data_sram_addr / data_sram_wdata  out  32 / 32  ` SRAM address and write data.
- `forward_data  out  32  ` = `output_alu_result`.
- `forward_ready  out  1  ` forwarded value is final.

## Operation
- Handshake: `valid` reg; `allowin = !valid | (readygo & allowout)`; `validout = valid & readygo`; `refreshing = validin & allowin`. Refresh loads all input regs and sets `valid <= validin`; `valid` clears when the instruction leaves with no refill.
- `readygo = 1` for ops 0–11; for ops 12–15 it is 1 only in divider state DONE.
- ALU: ADD/SUB modulo 2^32; SLT signed and SLTU unsigned give 0/1; shifts use `src2[4:0]`, SRA sign-fills; LUI returns `src2` (already shifted by decode).
- Divider FSM, IDLE→RUN→DONE→IDLE:
  - IDLE, `valid` & div op → RUN; load `|src1|`, `|src2|` (raw for DIVU/MODU); counter = 0.
  - RUN: restoring division, one quotient bit per cycle, 32 cycles → DONE.
  - DONE: sign-corrected result held. Quotient negative iff signs differ; remainder takes the dividend's sign. Returns to IDLE when the instruction leaves.
  - Divide by zero: quotient `0xFFFFFFFF`, remainder = `src1`.
  - `0x80000000 / -1`: quotient `0x80000000`, remainder 0.
- Memory request is combinational: `data_sram_en = valid & readygo & allowout & (mem_read | mem_write)`; `data_sram_we = {4{en & mem_write}}`; `addr = alu_result`; `wdata = store_data`. A request fires only in the cycle the instruction advances to MEM.
- `forward_ready = valid & readygo & !mem_read`.

## Timing
- Single-cycle ops: latched at edge E0, `validout` high in the following cycle; throughput one per cycle.
- Divide: latched at E0; cycle 0 IDLE; RUN at E1..E32; DONE at E33; `validout` high from cycle 33 until accepted. Back-to-back divides: the second enters IDLE at the leave edge, then +33 cycles.
- With `allowout = 0` in DONE: result, state and outputs hold; `data_sram_en` stays 0.
- Reset, including mid-divide: all regs 0, FSM IDLE, `valid = 0`. Outputs: `validout = 0`, `allowin = 1`, `data_sram_en = 0`, `data_sram_we = 0`, `forward_ready = 0`, all data outputs 0.

## Configuration
- `EXE_DIV_EN` defined: divider FSM and ops 12–15 present as above.
- Undefined: no divider logic; ops 12–15 return 0 with `readygo = 1` (single-cycle).

## Test plan
- ADD 5 + 7, `allowout = 1` → `output_alu_result = 12` and `validout` the next cycle; `forward_ready = 1`.
- Load with `src1 = 0x1000`, `src2 = 4`, `allowout` low for 2 cycles then high → `data_sram_en = 1`, `addr = 0x1004`, `we = 0` only in the release cycle; `output_mem_read = 1`; `forward_ready = 0`.
- DIV `-7 / 2` → quotient `0xFFFFFFFD` at cycle 33; MOD → `0xFFFFFFFF`; `allowin = 0` cycles 0–32.
- DIVU `x / 0` with `src1 = 9` → `0xFFFFFFFF`; MODU → 9; DIV `0x80000000 / -1` → `0x80000000`.
- `rst` asserted in RUN cycle 10 → outputs at reset values immediately; an ADD afterwards completes in 1 cycle.
- Store in DONE-blocked sequence: DIV then SW with `allowout = 1` → SW request (`we = 4'hF`) fires the cycle after the DIV leaves.

Source files
------------

// File: rtl/stage_exe_if.sv
// Bundle of the execute stage's pipeline handshake, operand/control inputs,
// MEM-stage outputs, data-SRAM request and forwarding path.
// master: the environment side (decode + MEM + SRAM); slave: stage_exe.
interface stage_exe_if;
  logic        validin, allowin, validout, allowout;
  logic [31:0] input_pc, output_pc;
  logic [4:0]  input_rf_waddr, output_rf_waddr;
  logic        input_rf_we, output_rf_we;
  logic [3:0]  input_alu_op;
  logic [31:0] input_alu_src1, input_alu_src2;
  logic        input_mem_read, input_mem_write;
  logic [31:0] input_store_data;
  logic        output_mem_read;
  logic [31:0] output_alu_result;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [31:0] forward_data;
  logic        forward_ready;

  modport master (
    output validin, allowout, input_pc, input_rf_waddr, input_rf_we, input_alu_op,
           input_alu_src1, input_alu_src2, input_mem_read, input_mem_write, input_store_data,
    input  allowin, validout, output_pc, output_rf_waddr, output_rf_we, output_mem_read,
           output_alu_result, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           forward_data, forward_ready
  );

  modport slave (
    input  validin, allowout, input_pc, input_rf_waddr, input_rf_we, input_alu_op,
           input_alu_src1, input_alu_src2, input_mem_read, input_mem_write, input_store_data,
    output allowin, validout, output_pc, output_rf_waddr, output_rf_we, output_mem_read,
           output_alu_result, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           forward_data, forward_ready
  );
endinterface

// File: rtl/stage_exe.sv
// Execute stage: latches decode's operands, computes the ALU result, issues
// the data-SRAM request as the instruction advances to MEM, and forwards the
// result back to decode.
// Optional macro EXE_DIV_EN: adds the 32-cycle restoring divider for ops
// 12-15 (DIV, MOD, DIVU, MODU). Without it those ops return 0 in one cycle.
module stage_exe (
  input  logic        clk,
  input  logic        rst,
  stage_exe_if.slave  bus
);
  // Instruction register
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic        rf_we_q, rf_we_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] src1_q, src1_d, src2_q, src2_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] store_data_q, store_data_d;

  logic        readygo, allowin, validout, refreshing, leaving, is_div;
  logic [31:0] alu_out, div_res, result;

  assign is_div     = (alu_op_q[3:2] == 2'b11);
  assign allowin    = !valid_q || (readygo && bus.allowout);
  assign validout   = valid_q && readygo;
  assign refreshing = bus.validin && allowin;
  assign leaving    = validout && bus.allowout;

  // Refresh loads a new instruction; valid follows validin whenever the slot opens
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rf_waddr_d   = rf_waddr_q;
    rf_we_d      = rf_we_q;
    alu_op_d     = alu_op_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    store_data_d = store_data_q;
    if (allowin) valid_d = bus.validin;
    if (refreshing) begin
      pc_d         = bus.input_pc;
      rf_waddr_d   = bus.input_rf_waddr;
      rf_we_d      = bus.input_rf_we;
      alu_op_d     = bus.input_alu_op;
      src1_d       = bus.input_alu_src1;
      src2_d       = bus.input_alu_src2;
      mem_read_d   = bus.input_mem_read;
      mem_write_d  = bus.input_mem_write;
      store_data_d = bus.input_store_data;
    end
  end

  // Instruction register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rf_waddr_q   <= '0;
      rf_we_q      <= 1'b0;
      alu_op_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      store_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_we_q      <= rf_we_d;
      alu_op_q     <= alu_op_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      store_data_q <= store_data_d;
    end
  end

  // Single-cycle ALU; LUI operand arrives pre-shifted from decode
  always_comb begin
    alu_out = '0;
    case (alu_op_q)
      4'd0:    alu_out = src1_q + src2_q;
      4'd1:    alu_out = src1_q - src2_q;
      4'd2:    alu_out = {31'b0, $signed(src1_q) < $signed(src2_q)};
      4'd3:    alu_out = {31'b0, src1_q < src2_q};
      4'd4:    alu_out = src1_q & src2_q;
      4'd5:    alu_out = src1_q | src2_q;
      4'd6:    alu_out = ~(src1_q | src2_q);
      4'd7:    alu_out = src1_q ^ src2_q;
      4'd8:    alu_out = src1_q << src2_q[4:0];
      4'd9:    alu_out = src1_q >> src2_q[4:0];
      4'd10:   alu_out = $signed(src1_q) >>> src2_q[4:0];
      4'd11:   alu_out = src2_q;
      default: alu_out = '0;
    endcase
  end

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [31:0] quo_q, quo_d;   // shifts out dividend bits, shifts in quotient bits
  logic [31:0] rem_q, rem_d;   // partial remainder
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic        div_signed, q_neg, r_neg;
  logic [32:0] shifted, diff;
  logic [31:0] q_step, r_step, q_fix, r_fix;

  assign div_signed = !alu_op_q[1];
  assign q_neg      = div_signed && (src1_q[31] ^ src2_q[31]);
  assign r_neg      = div_signed && src1_q[31];

  // One restoring step per RUN cycle; sign-correct and special-case on the last one
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    q_step  = {quo_q[30:0], !diff[32]};
    r_step  = diff[32] ? shifted[31:0] : diff[31:0];
    q_fix   = q_neg ? (32'd0 - q_step) : q_step;
    r_fix   = r_neg ? (32'd0 - r_step) : r_step;
    case (state_q)
      DIV_IDLE: begin
        if (valid_q && is_div) begin
          state_d = DIV_RUN;
          quo_d   = (div_signed && src1_q[31]) ? (32'd0 - src1_q) : src1_q;
          dvs_d   = (div_signed && src2_q[31]) ? (32'd0 - src2_q) : src2_q;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      DIV_RUN: begin
        quo_d = q_step;
        rem_d = r_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DIV_DONE;
          if (src2_q == 32'd0) res_d = alu_op_q[0] ? src1_q : 32'hFFFF_FFFF;
          else                 res_d = alu_op_q[0] ? r_fix  : q_fix;
        end
      end
      DIV_DONE: if (leaving) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Divider flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign readygo = !is_div || (state_q == DIV_DONE);
  assign div_res = res_q;
`else
  assign readygo = 1'b1;
  assign div_res = '0;
`endif

  assign result = is_div ? div_res : alu_out;

  assign bus.allowin           = allowin;
  assign bus.validout          = validout;
  assign bus.output_pc         = pc_q;
  assign bus.output_rf_waddr   = rf_waddr_q;
  assign bus.output_rf_we      = rf_we_q;
  assign bus.output_mem_read   = mem_read_q;
  assign bus.output_alu_result = result;
  // Request only in the cycle the instruction actually moves into MEM
  assign bus.data_sram_en      = leaving && (mem_read_q || mem_write_q);
  assign bus.data_sram_we      = {4{bus.data_sram_en && mem_write_q}};
  assign bus.data_sram_addr    = result;
  assign bus.data_sram_wdata   = store_data_q;
  assign bus.forward_data      = result;
  assign bus.forward_ready     = validout && !mem_read_q;
endmodule

// File: tb/tb_stage_exe.sv
// Self-checking bench for stage_exe: directed cases plus randomized ops
// compared against an arithmetic reference model. Follows EXE_DIV_EN.
module tb_stage_exe;
  logic clk = 1'b0;
  logic rst;
  stage_exe_if bus ();

  stage_exe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // Result of an op from the instruction-set rules
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    int sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return 32'(sa >>> sh);
      4'd11: return b;
`ifdef EXE_DIV_EN
      4'd12, 4'd13: begin
        if (b == 32'd0) return (op == 4'd12) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 4'd12) ? 32'h8000_0000 : 32'd0;
        return (op == 4'd12) ? 32'(sa / sb) : 32'(sa % sb);
      end
      4'd14, 4'd15: begin
        if (b == 32'd0) return (op == 4'd14) ? 32'hFFFF_FFFF : a;
        return (op == 4'd14) ? a / b : a % b;
      end
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef EXE_DIV_EN
    return (op >= 4'd12) ? 33 : 0;
`else
    return (op >= 4'd12) ? 0 : 0;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mr, input logic mw, input logic [31:0] sd,
                       input logic [31:0] pc, input logic [4:0] wa, input logic we);
    bus.validin          = 1'b1;
    bus.input_alu_op     = op;
    bus.input_alu_src1   = a;
    bus.input_alu_src2   = b;
    bus.input_mem_read   = mr;
    bus.input_mem_write  = mw;
    bus.input_store_data = sd;
    bus.input_pc         = pc;
    bus.input_rf_waddr   = wa;
    bus.input_rf_we      = we;
  endtask

  // Issue one instruction into an empty stage, stall MEM for 'stall' cycles
  // once the result is ready, then release and check the SRAM request.
  task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic mr, input logic mw, input logic [31:0] sd, input int stall);
    logic [31:0] pc  = $urandom;
    logic [4:0]  wa  = 5'($urandom_range(0, 31));
    logic        we  = 1'($urandom_range(0, 1));
    logic [31:0] exp = ref_alu(op, a, b);
    int cyc = 0;
    int early = 0;
    chk1("allowin_empty", bus.allowin, 1'b1);
    drive(op, a, b, mr, mw, sd, pc, wa, we);
    bus.allowout = (stall == 0);
    @(posedge clk); #1;
    bus.validin = 1'b0;
    while (bus.validout !== 1'b1 && cyc < 200) begin
      if (bus.allowin) early++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(ref_lat(op)));
    chk("allowin_busy", 32'(early), 32'd0);
    chk("result", bus.output_alu_result, exp);
    chk("forward_data", bus.forward_data, exp);
    chk1("forward_ready", bus.forward_ready, !mr);
    chk1("out_mem_read", bus.output_mem_read, mr);
    chk("out_pc", bus.output_pc, pc);
    chk("out_waddr", {27'b0, bus.output_rf_waddr}, {27'b0, wa});
    chk1("out_rf_we", bus.output_rf_we, we);
    for (int s = 0; s < stall; s++) begin
      chk1("sram_en_stalled", bus.data_sram_en, 1'b0);
      chk1("allowin_stalled", bus.allowin, 1'b0);
      @(posedge clk); #1;
      chk1("validout_held", bus.validout, 1'b1);
      chk("result_held", bus.output_alu_result, exp);
    end
    if (stall > 0) begin
      bus.allowout = 1'b1;
      #1;
    end
    chk1("sram_en", bus.data_sram_en, mr | mw);
    chk("sram_we", {28'b0, bus.data_sram_we}, mw ? 32'hF : 32'h0);
    if (mr | mw) begin
      chk("sram_addr", bus.data_sram_addr, exp);
      chk("sram_wdata", bus.data_sram_wdata, sd);
    end
    chk1("allowin_release", bus.allowin, 1'b1);
    @(posedge clk); #1;
    chk1("validout_drained", bus.validout, 1'b0);
  endtask

  initial begin
    logic [31:0] exp;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        mr, mw;
    int cyc;

    // Reset state
    rst = 1'b1;
    bus.allowout = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.validin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_validout", bus.validout, 1'b0);
    chk1("rst_allowin", bus.allowin, 1'b1);
    chk1("rst_sram_en", bus.data_sram_en, 1'b0);
    chk("rst_sram_we", {28'b0, bus.data_sram_we}, 32'd0);
    chk1("rst_fwd_ready", bus.forward_ready, 1'b0);
    chk("rst_result", bus.output_alu_result, 32'd0);
    chk("rst_pc", bus.output_pc, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    exec(4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 0);
    exec(4'd0, 32'h1000, 32'd4, 1'b1, 1'b0, 32'h1234_5678, 2);
    exec(4'd12, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 0);
    exec(4'd13, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 1);
    exec(4'd14, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 0);
    exec(4'd15, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 0);
    exec(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);
    exec(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);
    exec(4'd10, 32'h8000_0010, 32'd4, 1'b0, 1'b0, 32'd0, 0);

    // DIV followed by SW: the store's request fires the cycle after DIV leaves
    bus.allowout = 1'b1;
    drive(4'd12, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, 32'h40, 5'd3, 1'b1);
    @(posedge clk); #1;
    bus.validin = 1'b0;
    cyc = 0;
    while (bus.validout !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_div_latency", 32'(cyc), 32'(ref_lat(4'd12)));
    chk("b2b_div_result", bus.output_alu_result, ref_alu(4'd12, 32'd100, 32'hFFFF_FFFD));
    chk1("b2b_div_no_sram", bus.data_sram_en, 1'b0);
    drive(4'd0, 32'h200, 32'd8, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h44, 5'd0, 1'b0);
    #1;
    chk1("b2b_allowin", bus.allowin, 1'b1);
    @(posedge clk); #1;
    bus.validin = 1'b0;
    chk1("b2b_sw_validout", bus.validout, 1'b1);
    chk1("b2b_sw_en", bus.data_sram_en, 1'b1);
    chk("b2b_sw_we", {28'b0, bus.data_sram_we}, 32'hF);
    chk("b2b_sw_addr", bus.data_sram_addr, 32'h208);
    chk("b2b_sw_wdata", bus.data_sram_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    chk1("b2b_drained", bus.validout, 1'b0);

    // Reset in the middle of a divide
    drive(4'd12, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd0, 32'h80, 5'd1, 1'b1);
    bus.allowout = 1'b0;
    @(posedge clk); #1;
    bus.validin = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk1("midrst_validout", bus.validout, 1'b0);
    chk1("midrst_allowin", bus.allowin, 1'b1);
    chk1("midrst_fwd_ready", bus.forward_ready, 1'b0);
    chk("midrst_result", bus.output_alu_result, 32'd0);
    chk("midrst_pc", bus.output_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.allowout = 1'b1;
    exec(4'd0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 0);

    // Back-to-back single-cycle stream, one instruction per cycle
    bus.allowout = 1'b1;
    for (int i = 0; i < 50; i++) begin
      op = 4'($urandom_range(0, 11));
      a  = pick();
      b  = pick();
      drive(op, a, b, 1'b0, 1'b0, 32'd0, 32'(i), 5'd2, 1'b1);
      @(posedge clk); #1;
      chk1("stream_validout", bus.validout, 1'b1);
      chk("stream_result", bus.output_alu_result, ref_alu(op, a, b));
      chk1("stream_allowin", bus.allowin, 1'b1);
    end
    bus.validin = 1'b0;
    @(posedge clk); #1;
    chk1("stream_drained", bus.validout, 1'b0);

    // Randomized single instructions with random MEM stalls
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      mr = 1'b0;
      mw = 1'b0;
      case ($urandom_range(0, 3))
        0: begin mr = 1'b1; op = 4'd0; end
        1: begin mw = 1'b1; op = 4'd0; end
        default: ;
      endcase
      exec(op, a, b, mr, mw, $urandom, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
